// File: rtl/sdram_responder.sv
// Memory-side responder for the RAM/ROM strobe bus: one SDRAM access per cep slot,
// with power-up init and auto-refresh tucked into idle slots.
module sdram_responder #(
  parameter int SLOT_CLKS      = 8,
  parameter int CAS_LATENCY    = 2,
  parameter int INIT_WAIT      = 6500,
  parameter int REFRESH_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cep,
  input  logic [21:0] memoryAddr,
  input  logic        _memoryUDS,
  input  logic        _memoryLDS,
  input  logic        _romOE,
  input  logic        _ramOE,
  input  logic        _ramWE,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        ready,
  output logic [12:0] sd_addr,
  output logic [1:0]  sd_ba,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_dqm,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  input  logic [15:0] sd_dq_in
);

  localparam int PW = $clog2(SLOT_CLKS + 1);
  localparam int WW = $clog2(INIT_WAIT + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(SLOT_CLKS - 1);
  localparam logic [PW-1:0] PH_RESTART = PW'(4 + CAS_LATENCY);
  localparam logic [PW-1:0] PH_CAPTURE = PW'(2 + CAS_LATENCY);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(INIT_WAIT - 1);
  localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_CYCLES - 1);

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MODE  = 4'b0000;
  localparam logic [12:0] MODE_WORD = {3'b000, 1'b1, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000};

  typedef enum logic [2:0] {S_WAIT, S_PRE, S_REF1, S_REF2, S_MODE, S_RUN} init_t;
  typedef enum logic [1:0] {K_NONE, K_WRITE, K_READ} kind_t;

  init_t       init_q, init_d;
  kind_t       kind_q, kind_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RW-1:0] rtimer_q, rtimer_d;
  logic [PW-1:0] phase_q, phase_d;
  logic        busy_q, busy_d, pending_q, pending_d, rom_q, rom_d;
  logic [12:0] row_q, row_d;
  logic [8:0]  col_q, col_d;
  logic [1:0]  wmask_q, wmask_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d, dqm_q, dqm_d;
  logic [15:0] dq_out_q, dq_out_d, dout_q, dout_d;
  logic        dq_oe_q, dq_oe_d, dout_valid_q, dout_valid_d, ready_q, ready_d;
  logic        slot_start, req_any;

  // A new slot may overlap the tail of the previous one once its read data is captured.
  assign slot_start = cep && (init_q != S_WAIT) && (!busy_q || phase_q >= PH_RESTART);
  assign req_any    = !_ramWE || !_romOE || !_ramOE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q <= S_WAIT;      kind_q <= K_NONE;   wait_cnt_q <= '0;  rtimer_q <= REF_RELOAD;
      phase_q <= '0;         busy_q <= 1'b0;     pending_q <= 1'b0; rom_q <= 1'b0;
      row_q <= '0;           col_q <= '0;        wmask_q <= 2'b11;  wdata_q <= '0;
      cmd_q <= CMD_DESEL;    addr_q <= '0;       ba_q <= '0;        dqm_q <= 2'b11;
      dq_out_q <= '0;        dq_oe_q <= 1'b0;    dout_q <= '0;      dout_valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      init_q <= init_d;      kind_q <= kind_d;   wait_cnt_q <= wait_cnt_d; rtimer_q <= rtimer_d;
      phase_q <= phase_d;    busy_q <= busy_d;   pending_q <= pending_d;   rom_q <= rom_d;
      row_q <= row_d;        col_q <= col_d;     wmask_q <= wmask_d;       wdata_q <= wdata_d;
      cmd_q <= cmd_d;        addr_q <= addr_d;   ba_q <= ba_d;             dqm_q <= dqm_d;
      dq_out_q <= dq_out_d;  dq_oe_q <= dq_oe_d; dout_q <= dout_d;         dout_valid_q <= dout_valid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    init_d     = init_q;
    wait_cnt_d = wait_cnt_q;
    case (init_q)
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_LAST) init_d = S_PRE;
      end
      S_PRE:   if (slot_start) init_d = S_REF1;
      S_REF1:  if (slot_start) init_d = S_REF2;
      S_REF2:  if (slot_start) init_d = S_MODE;
      S_MODE:  if (slot_start) init_d = S_RUN;
      default: init_d = S_RUN;
    endcase
  end

  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    kind_d  = kind_q;
    rom_d   = rom_q;
    row_d   = row_q;
    col_d   = col_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    if (slot_start) begin
      busy_d  = 1'b1;
      phase_d = '0;
      row_d   = memoryAddr[21:9];
      col_d   = memoryAddr[8:0];
      wmask_d = {_memoryUDS, _memoryLDS};
      wdata_d = din;
      rom_d   = _ramWE && !_romOE;
      kind_d  = K_NONE;
      if (init_q == S_RUN) begin
        if (!_ramWE)      kind_d = K_WRITE;
        else if (req_any) kind_d = K_READ;
      end
    end else if (busy_q) begin
      if (phase_q == PH_LAST) busy_d = 1'b0;
      else                    phase_d = phase_q + 1'b1;
    end
  end

  always_comb begin
    cmd_d        = CMD_NOP;
    addr_d       = '0;
    ba_d         = '0;
    dqm_d        = 2'b11;
    dq_oe_d      = 1'b0;
    dq_out_d     = dq_out_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ready_d      = ready_q;
    pending_d    = pending_q;
    rtimer_d     = rtimer_q;
    if (slot_start) begin
      case (init_q)
        S_PRE:  begin cmd_d = CMD_PRE; addr_d[10] = 1'b1; end
        S_REF1, S_REF2: cmd_d = CMD_REF;
        S_MODE: begin cmd_d = CMD_MODE; addr_d = MODE_WORD; ready_d = 1'b1; end
        default: begin
          if (req_any) begin
            cmd_d  = CMD_ACT;
            addr_d = memoryAddr[21:9];
            ba_d   = {1'b0, _ramWE && !_romOE};
          end else if (pending_q && ready_q) begin
            cmd_d     = CMD_REF;
            pending_d = 1'b0;
          end
        end
      endcase
    end else if (busy_q && kind_q != K_NONE && phase_q == PW'(1)) begin
      addr_d = {2'b00, 1'b1, 1'b0, col_q};
      ba_d   = {1'b0, rom_q};
      if (kind_q == K_WRITE) begin
        cmd_d    = CMD_WRITE;
        dqm_d    = wmask_q;
        dq_oe_d  = 1'b1;
        dq_out_d = wdata_q;
      end else begin
        cmd_d = CMD_READ;
        dqm_d = 2'b00;
      end
    end
    if (busy_q && kind_q == K_READ && phase_q == PH_CAPTURE) begin
      dout_d       = sd_dq_in;
      dout_valid_d = 1'b1;
    end
    // A timer expiry in the same clk as a refresh issue leaves the flag set.
    if (!ready_q) begin
      rtimer_d = REF_RELOAD;
    end else if (rtimer_q == '0) begin
      rtimer_d  = REF_RELOAD;
      pending_d = 1'b1;
    end else begin
      rtimer_d = rtimer_q - 1'b1;
    end
  end

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
  assign sd_addr    = addr_q;
  assign sd_ba      = ba_q;
  assign sd_dqm     = dqm_q;
  assign sd_dq_out  = dq_out_q;
  assign sd_dq_oe   = dq_oe_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench for sdram_responder: a word-level reference memory and refresh-time
// arithmetic predict every command, data word and refresh slot.
module tb_sdram_responder;
  localparam int SLOT = 8, CL = 2, IW = 20, RC = 16;
  localparam logic [3:0] NOP = 4'b0111, DESEL = 4'b1111, ACT = 4'b0011, RD = 4'b0101,
                         WR = 4'b0100, PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

  logic clk = 0, reset = 1, cep = 0;
  logic [21:0] mem_addr = '0;
  logic uds_n = 1, lds_n = 1, romoe_n = 1, ramoe_n = 1, ramwe_n = 1;
  logic [15:0] din = '0, dout, sd_dq_out, sd_dq_in = '0;
  logic dout_valid, ready, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_dq_oe;
  logic [12:0] sd_addr;
  logic [1:0] sd_ba, sd_dqm;
  logic [3:0] cmd;
  assign cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

  int tests = 0, fails = 0, cyc = 0, ready_cyc = 0, last_ref = 0;
  logic [15:0] pad_mem [int];
  logic [15:0] ref_mem [int];
  logic [12:0] open_row [4];
  int rd_cnt = 0, rd_key = 0;
  logic [21:0] pool [6];

  sdram_responder #(.SLOT_CLKS(SLOT), .CAS_LATENCY(CL), .INIT_WAIT(IW), .REFRESH_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .cep(cep), .memoryAddr(mem_addr), ._memoryUDS(uds_n),
    ._memoryLDS(lds_n), ._romOE(romoe_n), ._ramOE(ramoe_n), ._ramWE(ramwe_n), .din(din),
    .dout(dout), .dout_valid(dout_valid), .ready(ready), .sd_addr(sd_addr), .sd_ba(sd_ba),
    .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n),
    .sd_dqm(sd_dqm), .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe), .sd_dq_in(sd_dq_in));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] word_init(input int k);
    logic [22:0] kk;
    kk = k[22:0];
    return kk[15:0] ^ {9'd0, kk[22:16]} ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] ref_read(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : word_init(k);
  endfunction

  function automatic logic [15:0] pad_read(input int k);
    return pad_mem.exists(k) ? pad_mem[k] : word_init(k);
  endfunction

  // Pending is set RC clks after ready and every RC clks after; cleared by the last refresh.
  function automatic bit exp_pending(input int t);
    int n;
    if (t - 1 - ready_cyc < RC) return 1'b0;
    n = (t - 1 - ready_cyc) / RC;
    return (ready_cyc + RC * n) >= last_ref;
  endfunction

  // SDRAM pad model: decodes the command bus, returns read data CL clks after READ.
  always @(negedge clk) begin
    if (reset) rd_cnt = 0;
    else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        sd_dq_in = (rd_cnt == 0) ? pad_read(rd_key) : 16'($urandom);
      end else sd_dq_in = 16'($urandom);
      case (cmd)
        ACT: open_row[sd_ba] = sd_addr;
        RD: begin rd_key = int'({sd_ba[0], open_row[sd_ba], sd_addr[8:0]}); rd_cnt = CL; end
        WR: if (sd_dq_oe) begin
          logic [15:0] w;
          int k;
          k = int'({sd_ba[0], open_row[sd_ba], sd_addr[8:0]});
          w = pad_read(k);
          if (!sd_dqm[1]) w[15:8] = sd_dq_out[15:8];
          if (!sd_dqm[0]) w[7:0] = sd_dq_out[7:0];
          pad_mem[k] = w;
        end
        default: ;
      endcase
    end
  end

  task automatic run_init();
    int n, first, spurious, rel;
    n = 0; first = -1; spurious = 0;
    reset = 1; cep = 0;
    repeat (2) @(negedge clk);
    reset = 0; rel = cyc;
    check_eq("rst_ready", ready, 0);
    for (int i = 0; i < 200 && n < 4; i++) begin
      cep = (i % 8 == 0);
      ramoe_n = 1'($urandom_range(0, 1));
      ramwe_n = 1'($urandom_range(0, 1));
      mem_addr = 22'($urandom);
      @(negedge clk);
      if (dout_valid) spurious++;
      if (cmd != NOP && cmd != DESEL) begin
        if (first < 0) first = cyc - rel;
        case (n)
          0: check_eq("init_pre", {cmd, sd_addr[10]}, {PRE, 1'b1});
          1: check_eq("init_ref1", cmd, REF);
          2: check_eq("init_ref2", {cmd, ready}, {REF, 1'b0});
          default: begin
            check_eq("init_mode", {cmd, sd_addr, sd_ba}, {MRS, 13'h220, 2'b00});
            check_eq("init_ready", ready, 1);
            ready_cyc = cyc;
          end
        endcase
        n++;
      end
    end
    cep = 0; ramoe_n = 1; ramwe_n = 1;
    check_eq("init_cmds", n, 4);
    check_eq("init_wait", first >= IW, 1);
    repeat (SLOT) begin
      @(negedge clk);
      if (dout_valid) spurious++;
    end
    check_eq("init_no_valid", spurious, 0);
    last_ref = 0;
  endtask

  // kind: 0 idle, 1 write, 2 rom read, 3 ram read, 4 write+rom conflict
  task automatic do_slot(input int kind, input logic [21:0] a, input logic u, input logic l,
                         input logic [15:0] d, input bit xcep, input bit rst3);
    bit wr, rdk, rom, acc, pend;
    int key, t0;
    logic [15:0] expd, old;
    wr = (kind == 1 || kind == 4); rdk = (kind == 2 || kind == 3);
    rom = (kind == 2); acc = wr || rdk;
    key = int'({rom, a});
    expd = ref_read(key);
    mem_addr = a; uds_n = u; lds_n = l; din = d;
    ramwe_n = !wr; romoe_n = !(kind == 2 || kind == 4); ramoe_n = !(kind == 3);
    cep = 1;
    for (int p = 0; p < SLOT; p++) begin
      @(negedge clk);
      if (p == 0) begin
        t0 = cyc;
        if (acc) check_eq("act", {cmd, sd_addr, sd_ba}, {ACT, a[21:9], 1'b0, rom});
        else begin
          pend = exp_pending(t0);
          check_eq("idle_t0", cmd, pend ? REF : NOP);
          if (pend) last_ref = t0;
        end
      end else if (p == 2 && acc) begin
        check_eq("rw_cmd", {cmd, sd_addr[10], sd_addr[8:0], sd_ba},
                 {wr ? WR : RD, 1'b1, a[8:0], 1'b0, rom});
        if (wr) check_eq("wr_bus", {sd_dqm, sd_dq_oe, sd_dq_out}, {u, l, 1'b1, d});
        else    check_eq("rd_dqm", {sd_dqm, sd_dq_oe}, 3'b000);
      end else begin
        check_eq("nop_bus", {cmd, sd_dq_oe, sd_dqm}, {NOP, 1'b0, 2'b11});
      end
      if (rdk && p == 3 + CL) check_eq("rd_data", {dout_valid, dout}, {1'b1, expd});
      else check_eq("valid_low", dout_valid, 0);
      if (p == 0) cep = 0;
      if (xcep && p == 1) cep = 1;
      if (xcep && p == 2) cep = 0;
      if (rst3 && p == 3) begin
        reset = 1;
        #1;
        check_eq("async_rst", {cmd, sd_addr, sd_ba, sd_dqm, sd_dq_oe, dout_valid, ready},
                 {DESEL, 13'h0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0});
        check_eq("async_rst_data", {dout, sd_dq_out}, 32'h0);
        break;
      end
    end
    if (wr && !rst3) begin
      old = ref_read(int'({1'b0, a}));
      ref_mem[int'({1'b0, a})] = {u ? old[15:8] : d[15:8], l ? old[7:0] : d[7:0]};
    end
    ramwe_n = 1; romoe_n = 1; ramoe_n = 1; uds_n = 1; lds_n = 1;
  endtask

  initial begin
    pool[0] = 22'h12345; pool[1] = 22'h000100;
    for (int i = 2; i < 6; i++) pool[i] = 22'($urandom);
    pad_mem[int'({1'b1, 22'h000100})] = 16'h4E71;
    ref_mem[int'({1'b1, 22'h000100})] = 16'h4E71;
    @(negedge clk);
    check_eq("reset_state", {cmd, sd_dqm, sd_dq_oe, dout_valid, ready}, {DESEL, 2'b11, 3'b000});
    run_init();
    do_slot(1, 22'h12345, 1'b0, 1'b1, 16'hBEEF, 0, 0);
    do_slot(2, 22'h000100, 1'b1, 1'b1, 16'h0, 0, 0);
    do_slot(4, pool[2], 1'b0, 1'b0, 16'h1234, 0, 0);
    do_slot(3, 22'h12345, 1'b0, 1'b0, 16'h0, 0, 0);
    do_slot(3, pool[2], 1'b0, 1'b0, 16'h0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      do_slot(3, pool[$urandom_range(0, 5)], 1'b0, 1'b0, 16'h0, 1, 0);
      do_slot(0, 22'h0, 1'b1, 1'b1, 16'h0, 0, 0);
    end
    for (int i = 0; i < 40; i++)
      do_slot($urandom_range(0, 4), pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 16'($urandom), 0, 0);
    do_slot(3, pool[0], 1'b0, 1'b0, 16'h0, 0, 1);
    run_init();
    for (int i = 0; i < 6; i++)
      do_slot($urandom_range(0, 4), pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 16'($urandom), 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Memory-side end of the address controller's RAM/ROM strobe interface; executes one access per bus slot against a single 16-bit SDRAM.
- Inputs per slot: word address, active-low byte strobes, _romOE/_ramOE/_ramWE, write data.
- Runs SDRAM power-up init and periodic auto-refresh, which are hidden in idle slots.
- Returns read data with fixed latency well before the next cep.

Parameters:
- SLOT_CLKS, 8, clk cycles per cep period; must be >= 5+CAS_LATENCY.
- CAS_LATENCY, 2, SDRAM CL (2 or 3), also written to the mode register.
- INIT_WAIT, 6500, clk cycles of NOP after reset before the init sequence (100 us at 65 MHz).
- REFRESH_CYCLES, 500, clk cycles between required refreshes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cep  in  1  slot start strobe, one clk wide
- memoryAddr  in  22  word address
- _memoryUDS  in  1  upper byte enable, active low
- _memoryLDS  in  1  lower byte enable, active low
- _romOE  in  1  ROM read, active low
- _ramOE  in  1  RAM read, active low
- _ramWE  in  1  RAM write, active low
- din  in  16  write data
- dout  out  16  read data
- dout_valid  out  1  one-clk pulse when dout updates
- ready  out  1  init complete
- sd_addr  out  13  SDRAM address
- sd_ba  out  2  bank
- sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n  out  1 each  command
- sd_dqm  out  2  byte masks [1]=upper
- sd_dq_out  out  16  write data
- sd_dq_oe  out  1  drive enable
- sd_dq_in  in  16  read data from pad

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- All SDRAM outputs and dout/dout_valid/ready are registered.
- Reset values:
  - sd_cs_n=1; ras_n/cas_n/we_n=1.
  - sd_addr=0, sd_ba=0, sd_dqm=2'b11, sd_dq_oe=0, sd_dq_out=0.
  - dout=0, dout_valid=0, ready=0.
  - phase=idle; refresh_pending=0.
- Reset asserted mid-access aborts immediately and restarts init.
- Address map:
  - col = memoryAddr[8:0]; row = memoryAddr[21:9].
  - ba = {1'b0, rom_access}, where rom_access is selected when _romOE=0.
- Request priority at slot sample: _ramWE=0 > _romOE=0 > _ramOE=0 > none.
- Slot timing: T0 is the edge at which cep=1 is sampled while phase is idle or >= 4+CAS_LATENCY.
  - A cep arriving earlier is ignored; the in-flight access completes.
  - Phase counter T0..T(SLOT_CLKS-1) then holds idle.
- Access slot:
  - T0 registers ACTIVE(row, ba).
  - T2 registers READ or WRITE with sd_addr[10]=1 (auto-precharge), col on sd_addr[8:0].
  - WRITE: sd_dq_oe=1, sd_dq_out=din, sd_dqm={_memoryUDS,_memoryLDS} for that one clk; both strobes high still issues the write, fully masked.
  - READ: sd_dqm=2'b00.
  - At edge T(3+CAS_LATENCY): dout<=sd_dq_in, dout_valid=1 for one clk (reads only).
  - All other phases: NOP (cs_n=0, ras/cas/we=1), dqm=11, dq_oe=0.
- Idle slot (no strobe) with refresh_pending=1 and ready=1: T0 issues AUTO REFRESH and clears refresh_pending. Otherwise NOP.
- Refresh timer:
  - Counts down from REFRESH_CYCLES-1 after ready.
  - At 0 sets refresh_pending and reloads.
  - Pending is a single flag; the host guarantees at least one idle slot per REFRESH_CYCLES.
- Init FSM: states WAIT, PRECHARGE, REF1, REF2, MODE, RUN.
  - WAIT: INIT_WAIT clks of NOP.
  - Each later state issues its command at T0 of successive cep slots, ignoring strobes.
  - PRECHARGE ALL: sd_addr[10]=1.
  - REF1, REF2: AUTO REFRESH.
  - MODE: LOAD MODE with sd_addr = {3'b000, 1'b1 single write, 2'b00, CL[2:0], 1'b0 sequential, 3'b000 burst 1}, ba=0.
  - ready<=1 at the edge MODE is issued.
  - Strobes during init produce no command and no dout_valid.

Test Plan:
- Reset release, INIT_WAIT=20, cep every 8 clk → command sequence PRE(A10=1), REF, REF, MODE with sd_addr=13'h220 (CL=2); ready rises on the MODE edge; no commands before clk 20.
- After ready: write memoryAddr=22'h12345, din=16'hBEEF, UDS=0 LDS=1, _ramWE=0 → ACTIVE row=13'h091, ba=0 at T0; WRITE col=9'h145, A10=1 at T2; sd_dqm=2'b01; dq_oe high for exactly one clk.
- ROM read memoryAddr=22'h000100, _romOE=0, model returns 16'h4E71 at CL → ACTIVE with ba=2'b01; dout=16'h4E71 and dout_valid pulse at T5.
- _ramWE=0 and _romOE=0 in the same slot → WRITE issued with ba=0; no dout_valid.
- REFRESH_CYCLES=16, alternate access/idle slots → AUTO REFRESH only at T0 of idle slots after pending sets; cep at T2 of an access is ignored and its read still returns.
- Reset pulsed at T3 of a read → outputs to reset values asynchronously; no dout_valid; init sequence restarts from WAIT.
